// File: rtl/rst_seq_pkg.sv
// Shared types for the board reset sequencer: sequencer states and reset-cause codes.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        SOC_REL = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_FPGA = 2'd1;
    localparam logic [1:0] CAUSE_MCU  = 2'd2;
    localparam logic [1:0] CAUSE_BOTH = 2'd3;

    // Bit 0 flags the FPGA button, bit 1 the MCU button, so codes can be OR-merged.
    function automatic logic [1:0] cause_encode(input logic fpga_db, input logic mcu_db);
        logic [1:0] code;
        case ({~mcu_db, ~fpga_db})
            2'b01:   code = CAUSE_FPGA;
            2'b10:   code = CAUSE_MCU;
            2'b11:   code = CAUSE_BOTH;
            default: code = CAUSE_POR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Button inputs and reset outputs of the board reset sequencer.
interface rst_seq_ctrl_if;
    logic       fpga_rst_n_i;
    logic       mcu_rst_n_i;
    logic       soc_erst_n_o;
    logic       periph_rst_o;
    logic [1:0] rst_cause_o;
    logic       seq_busy_o;

    modport master (
        output fpga_rst_n_i, mcu_rst_n_i,
        input  soc_erst_n_o, periph_rst_o, rst_cause_o, seq_busy_o
    );

    modport slave (
        input  fpga_rst_n_i, mcu_rst_n_i,
        output soc_erst_n_o, periph_rst_o, rst_cause_o, seq_busy_o
    );
endinterface

// File: rtl/btn_debounce.sv
// Synchronises one raw active-low push button and accepts a new level only after
// it has been stable for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 160000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_n,
    output logic btn_db
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   db_r;
    logic                   mismatch_s;

    // Plain flop chain into the core clock domain, released (high) in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw_n};
        end
    end

    assign mismatch_s = sync_r[SYNC_STAGES-1] ^ db_r;

    // Any return to the accepted level restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            db_r  <= 1'b1;
        end else if (!mismatch_s) begin
            cnt_r <= {CNT_W{1'b0}};
            db_r  <= db_r;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
            db_r  <= ~db_r;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            db_r  <= db_r;
        end
    end

    assign btn_db = db_r;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Board reset sequencer: debounces the FPGA/MCU buttons and releases the SoC reset
// and then the peripheral reset in a fixed order, recording what caused the reset.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 160000,
    parameter int unsigned HOLD_CYCLES     = 1024,
    parameter int unsigned PERIPH_DELAY    = 16
) (
    input  logic          clk,
    input  logic          rst,
    rst_seq_ctrl_if.slave bus
);

    localparam int unsigned       HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned       PER_W    = $clog2(PERIPH_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(PERIPH_DELAY);
    localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);

    seq_state_e        state_r, state_nx_s;
    logic              fpga_db_s, mcu_db_s, req_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [PER_W-1:0]  per_cnt_r;
    logic              hold_done_s, per_done_s;
    logic              soc_erst_n_nx_s, periph_rst_nx_s, busy_nx_s;
    logic              soc_erst_n_r, periph_rst_r, busy_r;
    logic [1:0]        cause_nx_s, cause_r;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fpga_db (
        .clk(clk), .rst(rst), .btn_raw_n(bus.fpga_rst_n_i), .btn_db(fpga_db_s)
    );

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mcu_db (
        .clk(clk), .rst(rst), .btn_raw_n(bus.mcu_rst_n_i), .btn_db(mcu_db_s)
    );

    assign req_s       = ~fpga_db_s | ~mcu_db_s;
    assign hold_done_s = (hold_cnt_r == HOLD_MAX);
    assign per_done_s  = (per_cnt_r == PER_MAX);

    // Next-state logic; a button request always wins and returns to ASSERT.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ASSERT:  if (!req_s) state_nx_s = HOLD; else state_nx_s = ASSERT;
            HOLD:    if (req_s) state_nx_s = ASSERT;
                     else if (hold_done_s) state_nx_s = SOC_REL;
                     else state_nx_s = HOLD;
            SOC_REL: if (req_s) state_nx_s = ASSERT;
                     else if (per_done_s) state_nx_s = RUN;
                     else state_nx_s = SOC_REL;
            RUN:     if (req_s) state_nx_s = ASSERT; else state_nx_s = RUN;
            default: state_nx_s = ASSERT;
        endcase
    end

    // Output decode from the next state so registered outputs move with the state.
    always_comb begin
        soc_erst_n_nx_s = 1'b0;
        periph_rst_nx_s = 1'b1;
        busy_nx_s       = 1'b1;
        case (state_nx_s)
            SOC_REL: soc_erst_n_nx_s = 1'b1;
            RUN: begin
                soc_erst_n_nx_s = 1'b1;
                periph_rst_nx_s = 1'b0;
                busy_nx_s       = 1'b0;
            end
            default: soc_erst_n_nx_s = 1'b0;
        endcase
    end

    // Cause is replaced on entry to ASSERT and accumulates new presses while there.
    always_comb begin
        cause_nx_s = cause_r;
        if (req_s && (state_nx_s == ASSERT)) begin
            if (state_r == ASSERT) cause_nx_s = cause_r | cause_encode(fpga_db_s, mcu_db_s);
            else cause_nx_s = cause_encode(fpga_db_s, mcu_db_s);
        end else begin
            cause_nx_s = cause_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ASSERT;
            soc_erst_n_r <= 1'b0;
            periph_rst_r <= 1'b1;
            busy_r       <= 1'b1;
            cause_r      <= CAUSE_POR;
        end else begin
            state_r      <= state_nx_s;
            soc_erst_n_r <= soc_erst_n_nx_s;
            periph_rst_r <= periph_rst_nx_s;
            busy_r       <= busy_nx_s;
            cause_r      <= cause_nx_s;
        end
    end

    // Hold counter restarts on HOLD entry; the release counter already counts its entry edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
            per_cnt_r  <= {PER_W{1'b0}};
        end else begin
            if (state_r != HOLD) hold_cnt_r <= {HOLD_W{1'b0}};
            else if (!hold_done_s) hold_cnt_r <= hold_cnt_r + HOLD_ONE;
            else hold_cnt_r <= hold_cnt_r;

            if (state_nx_s != SOC_REL) per_cnt_r <= {PER_W{1'b0}};
            else if (!per_done_s) per_cnt_r <= per_cnt_r + PER_ONE;
            else per_cnt_r <= per_cnt_r;
        end
    end

    assign bus.soc_erst_n_o = soc_erst_n_r;
    assign bus.periph_rst_o = periph_rst_r;
    assign bus.rst_cause_o  = cause_r;
    assign bus.seq_busy_o   = busy_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a step table of {inputs, cycles, expected outputs}
// plus a hand-written asynchronous reset sequence.
module tb_rst_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rst_seq_ctrl_if bus_if ();

    rst_seq_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(16), .PERIPH_DELAY(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_if)
    );

    typedef struct {
        logic       rst;
        logic       fpga_n;
        logic       mcu_n;
        int         cycles;
        logic       soc_erst_n;
        logic       periph_rst;
        logic [1:0] cause;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic add(input logic r, input logic f, input logic m, input int n,
                       input logic s, input logic p, input logic [1:0] c, input logic b);
        vec_t v;
        v.rst = r; v.fpga_n = f; v.mcu_n = m; v.cycles = n;
        v.soc_erst_n = s; v.periph_rst = p; v.cause = c; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus_if.soc_erst_n_o, bus_if.periph_rst_o, bus_if.rst_cause_o, bus_if.seq_busy_o};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got soc_erst_n=%b periph_rst=%b cause=%0d busy=%b, want soc_erst_n=%b periph_rst=%b cause=%0d busy=%b",
                     name, act[4], act[3], act[2:1], act[0], exp[4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    // Inputs are applied between edges; the sample is taken on the falling edge after the n-th rising edge.
    task automatic step(input string name, input vec_t v);
        rst = v.rst;
        bus_if.fpga_rst_n_i = v.fpga_n;
        bus_if.mcu_rst_n_i  = v.mcu_n;
        repeat (v.cycles) @(posedge clk);
        @(negedge clk);
        check(name, {v.soc_erst_n, v.periph_rst, v.cause, v.busy});
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        bus_if.fpga_rst_n_i = 1'b1;
        bus_if.mcu_rst_n_i  = 1'b1;

        // Power-on: HOLD entered on edge 1, SoC release at edge 18, peripheral release at edge 22.
        add(1'b1, 1'b1, 1'b1,  2, 1'b0, 1'b1, 2'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 17, 1'b0, 1'b1, 2'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b1, 2'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1,  3, 1'b1, 1'b1, 2'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b0, 2'd0, 1'b0);
        // 5-cycle MCU glitch in RUN is ignored.
        add(1'b0, 1'b1, 1'b0,  5, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b0, 2'd0, 1'b0);
        // FPGA button held 30 cycles: assert at edge 11, replay 11/28/32 after release.
        add(1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 19, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 27, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1,  3, 1'b1, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b0, 2'd1, 1'b0);
        // FPGA press/release, then MCU pressed at HOLD entry so it debounces at HOLD count 10.
        add(1'b0, 1'b0, 1'b1, 11, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b1, 11, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 2'd1, 1'b1);
        add(1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b1, 1'b0,  8, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b1, 1'b1, 27, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b1, 1'b1,  4, 1'b1, 1'b0, 2'd2, 1'b0);
        // Both pressed together; FPGA released first, SoC stays in reset until MCU release.
        add(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b0, 1'b0,  9, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1, 27, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1,  1, 1'b1, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1,  4, 1'b1, 1'b0, 2'd3, 1'b0);
        // MCU press replaces cause; FPGA press while in ASSERT ORs its bit in.
        add(1'b0, 1'b1, 1'b0, 11, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 2'd2, 1'b1);
        add(1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1, 28, 1'b1, 1'b1, 2'd3, 1'b1);
        add(1'b0, 1'b1, 1'b1,  4, 1'b1, 1'b0, 2'd3, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("step%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle in RUN: outputs drop before the next clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", {1'b0, 1'b1, 2'd0, 1'b1});
        @(negedge clk);
        v = '{1'b0, 1'b1, 1'b1, 17, 1'b0, 1'b1, 2'd0, 1'b1};
        step("rerun_hold", v);
        v = '{1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 2'd0, 1'b1};
        step("rerun_soc_rel", v);
        v = '{1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b0, 2'd0, 1'b0};
        step("rerun_run", v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Board-level reset sequencer that sits directly upstream of the SoC top and the peripheral logic. It conditions the two raw push-button resets (FPGA reset and MCU reset, both active-low and bouncy) in the 16 MHz core clock domain. It drives the SoC AON external reset (io_pads_aon_erst_n_i_ival) and the peripheral reset with a defined, staged release order, and records the reset cause. Its rst input is tied to ~mmcm_locked at top level, so an MMCM unlock acts as a power-on reset.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per button input (min 2)
DEBOUNCE_CYCLES, 160000, consecutive stable cycles before a button level is accepted (10 ms at 16 MHz)
HOLD_CYCLES, 1024, cycles the SoC reset stays asserted after all requests clear
PERIPH_DELAY, 16, cycles between SoC reset release and peripheral reset release

Ports:
clk  input  1  core clock, 16 MHz
rst  input  1  asynchronous active-high reset (from ~mmcm_locked)
fpga_rst_n_i  input  1  raw FPGA reset button, active-low, asynchronous
mcu_rst_n_i  input  1  raw MCU reset button, active-low, asynchronous
soc_erst_n_o  output  1  SoC AON external reset, active-low, registered
periph_rst_o  output  1  peripheral reset, active-high, registered
rst_cause_o  output  2  cause of last reset: 0 = power-on/unlock, 1 = FPGA button, 2 = MCU button, 3 = both
seq_busy_o  output  1  high in every state except RUN

Behaviour:
- Reset values while rst is high:
  - soc_erst_n_o = 0, periph_rst_o = 1, rst_cause_o = 0, seq_busy_o = 1.
  - Synchroniser flops = 1 (released); debounced levels = 1; FSM in ASSERT; counters = 0.
- Synchroniser: SYNC_STAGES flops per button, no logic between stages.
- Debounce, per button, independent:
  - The counter increments while the synced level differs from the debounced level and clears when they match.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present; the counter clears on the flip.
  - Any bounce back to the debounced level clears the counter, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
- req = ~fpga_db | ~mcu_db.
- FSM states:
  - ASSERT: soc_erst_n = 0, periph_rst = 1. Leave to HOLD when req = 0; the hold counter clears on entry to HOLD.
  - HOLD: counts HOLD_CYCLES cycles. On req go to ASSERT. On count done go to SOC_REL.
  - SOC_REL: soc_erst_n = 1, periph_rst = 1. Counts PERIPH_DELAY cycles. On req go to ASSERT. On count done go to RUN.
  - RUN: soc_erst_n = 1, periph_rst = 0, seq_busy = 0. On req go to ASSERT.
- Outputs are decoded from the next state and registered, so each changes on the same edge as the state transition. There is no combinational path from any input to any output.
- Latency from a debounced press to the assertion of both resets is 1 edge, from any state.
- rst_cause_o:
  - Captured on every transition into ASSERT caused by req, encoded as {~mcu_db, ~fpga_db}.
  - A button that becomes pressed while already in ASSERT ORs its bit into the cause.
  - Holds its value otherwise; cleared to 0 only by rst.
- Counter widths are $clog2(param+1). Counters saturate and do not wrap.
- Asynchronous rst mid-sequence: all outputs go to their reset values immediately, without waiting for a clock edge. The full sequence reruns after rst deasserts.
- Both buttons held: the FSM stays in ASSERT until both are debounced as released.

Decomposition:
- Shared package rst_seq_pkg holds:
  - the state enum: ASSERT, HOLD, SOC_REL, RUN;
  - the cause codes: CAUSE_POR, CAUSE_FPGA, CAUSE_MCU, CAUSE_BOTH.
- One sub-module, btn_debounce (synchroniser plus debounce counter, parameters SYNC_STAGES and DEBOUNCE_CYCLES), instantiated twice.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, HOLD_CYCLES=16, PERIPH_DELAY=4.
1. Power-on: release rst with both buttons high -> soc_erst_n_o rises at edge 18, periph_rst_o falls at edge 22, seq_busy_o falls with it, rst_cause_o = 0.
2. Glitch rejection: in RUN, drive mcu_rst_n_i low for 5 cycles -> no output change, rst_cause_o stays 0.
3. FPGA button: in RUN, hold fpga_rst_n_i low for 30 cycles -> both resets assert 2+8+1 edges after the press, rst_cause_o = 1. On release the full HOLD/SOC_REL/RUN sequence replays with the timing of scenario 1, offset by the debounce delay.
4. Re-press during HOLD: press the MCU button at HOLD count 10 -> FSM returns to ASSERT, rst_cause_o = 2, and a complete HOLD_CYCLES period restarts after release.
5. Simultaneous press: press both buttons on the same cycle -> rst_cause_o = 3; soc_erst_n_o stays low until the later of the two debounced releases.
6. Async reset in RUN: pulse rst high mid-cycle -> soc_erst_n_o = 0 and periph_rst_o = 1 before the next clock edge, rst_cause_o = 0, then the scenario 1 sequence follows.
